// File: rtl/result_uart_tx_pkg.sv
// Shared definitions for the result UART transmitter: packet constants,
// bit-level FSM states and the packet checksum.
package result_uart_tx_pkg;

  localparam logic [7:0] PKT_HEADER = 8'hA5;
  localparam int         PKT_LEN    = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // Sum of payload bytes 1..5; the header is excluded and the carry is dropped.
  function automatic logic [7:0] calc_checksum(input logic [15:0] freq,
                                               input logic [15:0] amp,
                                               input logic        pass);
    return freq[15:8] + freq[7:0] + amp[15:8] + amp[7:0] + {7'b0, pass};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, d0..d7 LSB first, stop bit, each held
// CLKS_PER_BIT cycles. A load during the final stop cycle chains the next byte.
module uart_tx_byte
  import result_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             tx_nxt;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // decisions live in the always_comb below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_nxt    = state;
    baud_cnt_nxt = bit_end ? '0 : baud_cnt + 1'b1;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    tx_nxt       = tx;
    byte_done    = 1'b0;

    case (state)
      ST_IDLE: begin
        baud_cnt_nxt = '0;
        if (load) begin
          state_nxt = ST_START;
          shift_nxt = data;
          tx_nxt    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt   = ST_DATA;
          bit_idx_nxt = 3'd0;
          tx_nxt      = shift[0];
          shift_nxt   = shift >> 1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nxt = ST_STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            tx_nxt      = shift[0];
            shift_nxt   = shift >> 1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          byte_done = 1'b1;
          if (load) begin
            state_nxt = ST_START;
            shift_nxt = data;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/result_uart_tx.sv
// Captures one analysis result on send_req and transmits it as a 7-byte
// UART packet: header, freq hi/lo, amp hi/lo, pass flag, checksum.
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int         CLK_FREQ_HZ  = 50_000_000,
  parameter int         BAUD         = 115_200,
  parameter int         CLKS_PER_BIT = CLK_FREQ_HZ / BAUD,
  parameter logic [7:0] HEADER       = PKT_HEADER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_req,
  input  logic [15:0] freq_in,
  input  logic [15:0] amp_in,
  input  logic        pass_in,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic        tx
);

  localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);

  logic [15:0] freq_q, amp_q;
  logic        pass_q;
  logic [2:0]  byte_idx, next_idx;
  logic [7:0]  tx_byte, checksum;
  logic        accept, advance, load, byte_done;

  assign accept   = send_req && !busy;
  assign advance  = byte_done && (byte_idx != LAST_IDX);
  assign load     = accept || advance;
  assign next_idx = accept ? 3'd0 : byte_idx + 3'd1;
  assign checksum = calc_checksum(freq_q, amp_q, pass_q);

  // Byte 0 is a constant, so it can be loaded on the same edge that captures.
  always_comb begin
    tx_byte = HEADER;
    case (next_idx)
      3'd1:    tx_byte = freq_q[15:8];
      3'd2:    tx_byte = freq_q[7:0];
      3'd3:    tx_byte = amp_q[15:8];
      3'd4:    tx_byte = amp_q[7:0];
      3'd5:    tx_byte = {7'b0, pass_q};
      3'd6:    tx_byte = checksum;
      default: tx_byte = HEADER;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data     (tx_byte),
    .tx       (tx),
    .byte_done(byte_done)
  );

  // NOTE: the capture registers carry no reset; they are always written on
  // accept before any byte that reads them is loaded.
  always_ff @(posedge clk) begin
    if (accept) begin
      freq_q <= freq_in;
      amp_q  <= amp_in;
      pass_q <= pass_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      byte_idx <= '0;
    end else begin
      done    <= 1'b0;
      overrun <= send_req && busy;
      if (accept) begin
        busy     <= 1'b1;
        byte_idx <= 3'd0;
      end else if (advance) begin
        byte_idx <= byte_idx + 3'd1;
      end else if (byte_done) begin
        busy     <= 1'b0;
        done     <= 1'b1;
        byte_idx <= 3'd0;
      end
    end
  end

endmodule
